// File: rtl/uart_loopback_bist.sv
// UART loopback self-test: pushes a generated pattern over tx->rx and checks every word read back.
// Latency per word: 1 SEND cycle + UART transit + 1 capture + 1 CHECK. tx_full stalls SEND; a silent rx aborts after TIMEOUT.
// UART_BIST_CAPTURE_EN adds first-mismatch capture (fail_idx/fail_exp/fail_got); otherwise those ports read 0.
module uart_loopback_bist #(
  parameter int          DBIT      = 8,
  parameter int          NUM_BYTES = 16,
  parameter int          TIMEOUT   = 4096,
  parameter int unsigned SEED      = 8'h41,
  localparam int CNT_W = $clog2(NUM_BYTES + 1),
  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] err_cnt,
  output logic             wr_uart,
  output logic [DBIT-1:0]  w_data,
  input  logic             tx_full,
  output logic             rd_uart,
  input  logic [DBIT-1:0]  r_data,
  input  logic             rx_empty,
  output logic [IDX_W-1:0] fail_idx,
  output logic [DBIT-1:0]  fail_exp,
  output logic [DBIT-1:0]  fail_got
);

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [DBIT-1:0]  SEED_W  = DBIT'(SEED);
  localparam logic [DBIT-1:0]  ONE     = DBIT'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {IDLE, SEND, WAIT_RX, CHECK, DONE} state_t;

  state_t           state_q, state_d;
  logic             mode_q, mode_d;
  logic [DBIT-1:0]  pat_q, pat_d;
  logic [DBIT-1:0]  got_q, got_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             timeout_q, timeout_d;
  logic             pass_q, pass_d;

  logic             mismatch;
  logic             start_ok;
  logic [DBIT-1:0]  shx;
  logic [DBIT-1:0]  pat_next;

  always_comb begin
    shx      = {pat_q[DBIT-2:0], pat_q[DBIT-1] ^ pat_q[DBIT-2]};
    pat_next = mode_q ? ((shx == '0) ? ONE : shx) : (pat_q + ONE);
    mismatch = (got_q != pat_q);
    start_ok = start && ((state_q == IDLE) || (state_q == DONE));
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    pat_d     = pat_q;
    got_d     = got_q;
    idx_d     = idx_q;
    to_cnt_d  = to_cnt_q;
    err_cnt_d = err_cnt_q;
    timeout_d = timeout_q;
    pass_d    = pass_q;
    wr_uart   = 1'b0;
    rd_uart   = 1'b0;
    w_data    = '0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = SEND;
          err_cnt_d = '0;
          timeout_d = 1'b0;
          pass_d    = 1'b0;
          idx_d     = '0;
          to_cnt_d  = '0;
          mode_d    = mode;
          // An all-zero seed would lock the shift-xor sequence at zero.
          pat_d     = (mode && (SEED_W == '0)) ? ONE : SEED_W;
        end
      end
      SEND: begin
        w_data  = pat_q;
        wr_uart = !tx_full;
        if (!tx_full) begin
          state_d  = WAIT_RX;
          to_cnt_d = '0;
        end
      end
      WAIT_RX: begin
        if (!rx_empty) begin
          rd_uart = 1'b1;
          got_d   = r_data;
          state_d = CHECK;
        end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          state_d   = DONE;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      CHECK: begin
        if (mismatch && (err_cnt_q != CNT_MAX)) begin
          err_cnt_d = err_cnt_q + 1'b1;
        end
        if (idx_q == IDX_W'(NUM_BYTES - 1)) begin
          state_d = DONE;
          pass_d  = !mismatch && (err_cnt_q == '0);
        end else begin
          idx_d   = idx_q + 1'b1;
          pat_d   = pat_next;
          state_d = SEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      pat_q     <= '0;
      got_q     <= '0;
      idx_q     <= '0;
      to_cnt_q  <= '0;
      err_cnt_q <= '0;
      timeout_q <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      pat_q     <= pat_d;
      got_q     <= got_d;
      idx_q     <= idx_d;
      to_cnt_q  <= to_cnt_d;
      err_cnt_q <= err_cnt_d;
      timeout_q <= timeout_d;
      pass_q    <= pass_d;
    end
  end

  assign busy    = (state_q == SEND) || (state_q == WAIT_RX) || (state_q == CHECK);
  assign done    = (state_q == DONE);
  assign pass    = pass_q;
  assign timeout = timeout_q;
  assign err_cnt = err_cnt_q;

`ifdef UART_BIST_CAPTURE_EN
  logic [IDX_W-1:0] fail_idx_q, fail_idx_d;
  logic [DBIT-1:0]  fail_exp_q, fail_exp_d;
  logic [DBIT-1:0]  fail_got_q, fail_got_d;

  always_comb begin
    fail_idx_d = fail_idx_q;
    fail_exp_d = fail_exp_q;
    fail_got_d = fail_got_q;
    if (start_ok) begin
      fail_idx_d = '0;
      fail_exp_d = '0;
      fail_got_d = '0;
    end else if ((state_q == CHECK) && mismatch && (err_cnt_q == '0)) begin
      // err_cnt still zero means this is the run's first mismatch.
      fail_idx_d = idx_q;
      fail_exp_d = pat_q;
      fail_got_d = got_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fail_idx_q <= '0;
      fail_exp_q <= '0;
      fail_got_q <= '0;
    end else begin
      fail_idx_q <= fail_idx_d;
      fail_exp_q <= fail_exp_d;
      fail_got_q <= fail_got_d;
    end
  end

  assign fail_idx = fail_idx_q;
  assign fail_exp = fail_exp_q;
  assign fail_got = fail_got_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
  assign fail_idx = '0;
  assign fail_exp = '0;
  assign fail_got = '0;
`endif

endmodule
